// File: rtl/icap_arbiter_pkg.sv
// Shared state encoding, helpers and ICAPE2 command words for the ICAP arbiter.
package icap_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] BURST   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [31:0] DUMMY_WORD  = 32'hFFFFFFFF;
    localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD   = 32'h20000000;
    localparam logic [31:0] WBSTAR_WORD = 32'h30020001;
    localparam logic [31:0] CMD_WORD    = 32'h30008001;
    localparam logic [31:0] IPROG_WORD  = 32'h0000000F;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/icap_arbiter_if.sv
// One requester's valid/ready/last word stream into the ICAP arbiter.
interface icap_arbiter_if;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/icap_arbiter_bitswap.sv
// Reverses bit order inside each byte of a config word (ICAPE2 X32 ordering).
module icap_bitswap (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        for (genvar i = 0; i < 8; i++) begin : g_bit
            assign dout[8*b+i] = din[8*b+7-i];
        end
    end
endmodule

// File: rtl/icap_arbiter.sv
// Round-robin burst arbiter sharing the ICAPE2 write port between two requesters.
// Build option ICAP_BITSWAP_EN: per-byte bit reversal of the words sent to ICAPE2.
module icap_arbiter
    import icap_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int GAP_CYC     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    icap_arbiter_if.slave req0,
    icap_arbiter_if.slave req1,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout,
    output logic [31:0]   icap_i,
    output logic          icap_csib,
    output logic          icap_rdwrb
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t        state;
    logic          owner;
    logic          rr;
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] gap_cnt;
    logic          own_valid;
    logic          own_last;
    logic          accept;
    logic [31:0]   own_data;
    logic [31:0]   word;

    assign own_valid = owner ? req1.valid : req0.valid;
    assign own_last  = owner ? req1.last  : req0.last;
    assign own_data  = owner ? req1.data  : req0.data;
    assign accept    = (state == BURST) && own_valid;

    assign busy       = (state != IDLE);
    assign grant      = (state == SETUP || state == BURST) ? owner_onehot(owner) : 2'b00;
    assign req0.ready = (state == BURST) && !owner;
    assign req1.ready = (state == BURST) && owner;

`ifdef ICAP_BITSWAP_EN
    icap_bitswap u_bitswap (.din(own_data), .dout(word));
`else
    assign word = own_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr         <= 1'b0;
            idle_cnt   <= '0;
            gap_cnt    <= '0;
            timeout    <= 1'b0;
            icap_i     <= DUMMY_WORD;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0.valid || req1.valid) begin
                        // rr names the requester that was not granted last
                        owner      <= (req0.valid && req1.valid) ? rr : req1.valid;
                        icap_rdwrb <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    idle_cnt <= '0;
                    state    <= BURST;
                end
                BURST: begin
                    if (accept) begin
                        icap_i    <= word;
                        icap_csib <= 1'b0;
                        idle_cnt  <= '0;
                        if (own_last) begin
                            gap_cnt <= '0;
                            state   <= RELEASE;
                        end
                    end else begin
                        icap_csib <= 1'b1;
                        if (idle_cnt != IW'(TIMEOUT_CYC))
                            idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == IW'(TIMEOUT_CYC - 1)) begin
                            timeout    <= 1'b1;
                            icap_rdwrb <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // the final word is still on the bus in the first cycle here;
                    // CSIB and RDWRB rise together so RDWRB never moves under CSIB=0
                    icap_csib  <= 1'b1;
                    icap_rdwrb <= 1'b1;
                    gap_cnt    <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        rr    <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icap_arbiter.sv
// Randomised bench for icap_arbiter: requester drivers, a write-stream scoreboard and an arbitration model.
module tb_icap_arbiter;
    import icap_pkg::*;

    localparam int TIMEOUT_CYC = 255;
    localparam int GAP_CYC     = 1;

    typedef struct {
        logic [31:0] w;
        logic        last;
        int          gap;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  v = '0;
    logic [1:0]  l = '0;
    logic [31:0] d [2];
    logic [1:0]  rdy;
    logic [1:0]  grant;
    logic        busy, timeout, csib, rdwrb;
    logic [31:0] icap_i;

    always #5 clk = ~clk;

    icap_arbiter_if r0 ();
    icap_arbiter_if r1 ();

    assign r0.valid = v[0];
    assign r0.data  = d[0];
    assign r0.last  = l[0];
    assign r1.valid = v[1];
    assign r1.data  = d[1];
    assign r1.last  = l[1];
    assign rdy      = {r1.ready, r0.ready};

    icap_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req0(r0), .req1(r1),
        .grant(grant), .busy(busy), .timeout(timeout),
        .icap_i(icap_i), .icap_csib(csib), .icap_rdwrb(rdwrb)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_writes = 0;
    int          n_to = 0;
    word_t       pend [2][$];
    logic [31:0] sb [$];
    logic [1:0]  started = '0;
    logic [1:0]  prev_v = '0;
    logic [1:0]  prev_grant = '0;
    logic        prev_rdwrb = 1'b1;
    logic        rst_prev = 1'b0;
    logic        exp_to = 1'b0;
    int          last_owner = 1;
    int          burst_idle = 0;
    int          gap_run = 0;
    logic        had_burst = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word as ICAPE2 must see it: bytes kept in place, bits reversed inside each byte.
    function automatic logic [31:0] icap_word(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
        logic [31:0] r;
        r = {<<{w}};
        return {<<8{r}};
`else
        return w;
`endif
    endfunction

    task automatic add_word(input int id, input logic [31:0] w, input logic last, input int gap);
        word_t e;
        e.w = w; e.last = last; e.gap = gap;
        pend[id].push_back(e);
    endtask

    task automatic add_burst(input int id, input int n, input int max_gap);
        for (int k = 0; k < n; k++)
            add_word(id, $urandom, 1'(k == n - 1), $urandom_range(0, max_gap));
    endtask

    task automatic monitor();
        if (!rst_prev) begin
            check("rst_csib",    32'(csib),    32'(1));
            check("rst_rdwrb",   32'(rdwrb),   32'(1));
            check("rst_icap_i",  icap_i,       DUMMY_WORD);
            check("rst_grant",   32'(grant),   32'(0));
            check("rst_ready",   32'(rdy),     32'(0));
            check("rst_timeout", 32'(timeout), 32'(0));
            sb.delete();
            for (int id = 0; id < 2; id++) begin
                while (started[id] && pend[id].size() != 0) begin
                    word_t e = pend[id].pop_front();
                    if (e.last) break;
                end
            end
            started = '0; last_owner = 1; burst_idle = 0; exp_to = 1'b0;
            gap_run = 0; had_burst = 1'b0;
        end else begin
            logic exp_wr;
            exp_wr = (sb.size() != 0);
            check("csib", 32'(csib), 32'(!exp_wr));
            if (exp_wr) begin
                check("icap_i", icap_i, icap_word(sb.pop_front()));
                check("rdwrb_under_csib", 32'({prev_rdwrb, rdwrb}), 32'(0));
                n_writes++; gap_run = 0; had_burst = 1'b1;
            end else if (csib && rdwrb) begin
                gap_run++;
            end
            if (!rdwrb && prev_rdwrb && had_burst)
                check("release_gap", 32'(gap_run >= GAP_CYC), 32'(1));
            check("timeout", 32'(timeout), 32'(exp_to));
            exp_to = 1'b0;
            if (timeout) n_to++;
            check("ready_non_owner", 32'(rdy & ~grant), 32'(0));
            check("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
            if (prev_grant == 2'b00 && grant != 2'b00) begin
                int win;
                win = (prev_v == 2'b11) ? 1 - last_owner : (prev_v[1] ? 1 : 0);
                check("grant_winner", 32'(grant), 32'(win ? 2'b10 : 2'b01));
                last_owner = win;
                burst_idle = 0;
            end
            for (int id = 0; id < 2; id++)
                if (started[id]) check("grant_held", 32'(grant), 32'(id ? 2'b10 : 2'b01));
            if (grant != 2'b00) check("busy", 32'(busy), 32'(1));
        end
    endtask

    task automatic step(input logic rst);
        @(posedge clk); #1;
        rst_n = rst;
        for (int id = 0; id < 2; id++) begin
            d[id] = $urandom;
            l[id] = 1'($urandom_range(0, 1));
            v[id] = 1'b0;
            if (pend[id].size() != 0) begin
                word_t e = pend[id][0];
                if (started[id] && e.gap > 0) begin
                    e.gap--;
                    pend[id][0] = e;
                end else begin
                    v[id] = 1'b1; d[id] = e.w; l[id] = e.last;
                end
            end
        end
        @(negedge clk);
        monitor();
        for (int id = 0; id < 2; id++) begin
            if (rst_n && rdy[id]) begin
                if (v[id]) begin
                    word_t e = pend[id].pop_front();
                    sb.push_back(e.w);
                    started[id] = !e.last;
                    burst_idle = 0;
                end else if (++burst_idle == TIMEOUT_CYC) begin
                    exp_to = 1'b1; started[id] = 1'b0; burst_idle = 0;
                end
            end
        end
        prev_v = v; prev_grant = grant; prev_rdwrb = rdwrb; rst_prev = rst_n;
    endtask

    task automatic run_until_idle(input int budget);
        int  i;
        logic done;
        i = 0; done = 1'b0;
        while (!done && i < budget) begin
            step(1'b1);
            done = (pend[0].size() == 0 && pend[1].size() == 0 && sb.size() == 0 && !busy);
            i++;
        end
        check("drain_left", 32'(pend[0].size() + pend[1].size() + sb.size()), 32'(0));
    endtask

    initial begin
        int w0, t0;
        // both requesters hold VALID through reset, then contend
        add_burst(0, 2, 0);
        add_burst(1, 2, 0);
        repeat (4) step(1'b0);
        run_until_idle(200);
        add_burst(0, 3, 1);
        add_burst(1, 3, 1);
        run_until_idle(200);

        // canonical sync preamble from req0
        w0 = n_writes;
        add_word(0, DUMMY_WORD, 1'b0, 0);
        add_word(0, SYNC_WORD,  1'b0, 0);
        add_word(0, NOOP_WORD,  1'b1, 0);
        run_until_idle(100);
        check("preamble_writes", 32'(n_writes - w0), 32'(3));

        for (int r = 0; r < 24; r++) begin
            int mask;
            mask = $urandom_range(1, 3);
            if (mask[0]) add_burst(0, $urandom_range(1, 6), 3);
            repeat ($urandom_range(0, 4)) step(1'b1);
            if (mask[1]) add_burst(1, $urandom_range(1, 6), 3);
            run_until_idle(600);
        end

        // req1 drops VALID for two cycles mid-burst
        add_word(1, CMD_WORD,    1'b0, 0);
        add_word(1, WBSTAR_WORD, 1'b0, 2);
        add_word(1, NOOP_WORD,   1'b1, 0);
        run_until_idle(100);

        // req0 stalls past the timeout while req1 waits
        t0 = n_to;
        add_word(0, $urandom, 1'b0, 0);
        add_word(0, $urandom, 1'b1, 300);
        repeat (3) step(1'b1);
        add_burst(1, 3, 0);
        run_until_idle(1200);
        check("timeout_pulses", 32'(n_to - t0), 32'(1));

        // reset mid-burst abandons the rest of it
        add_word(0, IPROG_WORD, 1'b0, 0);
        add_word(0, IPROG_WORD, 1'b0, 0);
        add_word(0, NOOP_WORD,  1'b1, 5);
        repeat (5) step(1'b1);
        step(1'b0);
        step(1'b0);
        add_burst(1, 2, 1);
        run_until_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
